mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the opcode and sequences fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select. It also produces the 4-bit ALUOp consumed by the ALU-control decoder (ula_ctrl), together with the funct field.

Parameters:
ALUOP_ADD, 4'b0010, ALUOp code that the ALU-control decoder resolves to add (used for PC+4, branch target, lw/sw address).
ALUOP_RTYPE, 4'b0000, ALUOp code that tells the ALU-control decoder to use funct.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  6  instr[31:26] from IR (valid from DECODE onward)
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake; access completes in the cycle it is high
ALUOp  out  4  to ALU-control decoder
ALUSrcA  out  1  0=PC, 1=regA
ALUSrcB  out  2  0=regB, 1=const 4, 2=ext imm, 3=ext imm<<2
ext_zero  out  1  1=zero-extend imm (andi/ori/xori), 0=sign-extend
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=MDR
RegWrite  out  1  register file write
PCSrc  out  2  0=ALU result, 1=ALUOut, 2=jump target
pc_en  out  1  PC load enable (PCWrite | beq&zero | bne&~zero)
illegal  out  1  one-cycle pulse on unknown opcode
state  out  4  current state, for debug

Behaviour:
- State register updates on the clk rising edge. Asynchronous reset forces FETCH.
- While reset is high, all of these are 0 regardless of state: MemRead, MemWrite, IRWrite, RegWrite, pc_en, illegal.
- Outputs are Moore, combinational from state, plus opcode where noted. Unlisted outputs are 0; ALUOp defaults to ALUOP_ADD.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ALUOP_ADD, PCSrc=0. IRWrite and pc_en equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ALUOP_ADD (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 001000, 001010, 001011, 001100, 001101, 001110 -> IMM_EX
  - 000010 -> JUMP
  - any other opcode -> FETCH, with illegal=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=ALUOP_ADD. sw goes to MEMWR; lw goes to MEMRD. ALUOp is never derived from the opcode here, because sw's low nibble (1011) collides with sltiu.
- MEMRD: MemRead=1, IorD=1. Wait while mem_ready=0, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait while mem_ready=0, then go to FETCH. MemWrite holds steady for the whole wait.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=0, ALUOp=ALUOP_RTYPE. Next RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp={2'b01,opcode[1:0]} (0100 or 0101), PCSrc=1.
  - pc_en = zero for beq, ~zero for bne.
  - Next FETCH.
- IMM_EX: ALUSrcA=1, ALUSrcB=2, ALUOp=opcode[3:0], ext_zero=opcode[2]. Next IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- JUMP: PCSrc=2, pc_en=1. Next FETCH.
- Latencies with mem_ready always 1:
  - lw 5 cycles
  - sw 4 cycles
  - R-type and I-type ALU 4 cycles
  - branch and jump 3 cycles
  - illegal 2 cycles
- Each mem_ready=0 cycle adds one cycle.
- Reset asserted mid-instruction aborts it. No write enable is asserted after reset rises, and execution restarts at FETCH after release.
- Unused state encodings go to FETCH.

Decomposition:
- A shared constants header holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_J)
  - ALUOp codes, shared with ula_ctrl
  - state encodings
- One sub-module is natural: mips_ctrl_outdec, a purely combinational state/opcode to control-word decoder. The state register and next-state logic stay in the top.

Test Plan:
- Reset high mid-MEMWR, then release -> MemWrite drops asynchronously; state=FETCH; first post-reset cycle has MemRead=1, IRWrite=1.
- lw (100011), mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; ALUOp=0010 in MEMADR; RegWrite=1 only in cycle 5 with MemtoReg=1.
- sw (101011), mem_ready low for 3 cycles in MEMWR -> MemWrite high for 4 cycles; ALUOp=0010, never 1011.
- beq with zero=1 gives pc_en=1 in BRANCH; bne with zero=1 gives pc_en=0. ALUOp is 0100 and 0101 respectively.
- andi (001100) -> IMM_EX has ALUOp=1100, ext_zero=1; addi (001000) -> ALUOp=1000, ext_zero=0; both then RegWrite in IMM_WB with RegDst=0.
- Opcode 111111 -> illegal pulses in DECODE; next state FETCH; no RegWrite, MemWrite or pc_en asserted.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, ALUOp codes,
// state encodings and the control-word payload driven into the datapath.
package mips_multicycle_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // Shared with ula_ctrl
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 4'b0000;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        IMM_EX   = 4'd9,
        IMM_WB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic               ext_zero;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
        logic [1:0]         pc_src;
        logic               pc_en;
        logic               illegal;
    } ctrl_t;

    // DECODE successor; FETCH doubles as the "unknown opcode" marker.
    function automatic state_e decode_target(input logic [OP_W-1:0] op);
        state_e nxt;
        case (op)
            OP_LW, OP_SW:                 nxt = MEMADR;
            OP_RTYPE:                     nxt = RTYPE_EX;
            OP_BEQ, OP_BNE:               nxt = BRANCH;
            OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:     nxt = IMM_EX;
            OP_J:                         nxt = JUMP;
            default:                      nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: maps current state (plus opcode, zero
// and mem_ready where the state needs them) to every datapath enable/select.
module mips_ctrl_outdec
    import mips_multicycle_ctrl_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALUOP_ADD;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = 2'd1;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_b = 2'd3;
                ctrl_o.illegal   = (decode_target(opcode_i) == FETCH);
            end
            // Address calc stays on ADD: sw's low nibble would alias sltiu
            MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'd2;
            end
            MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            RTYPE_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_RTYPE;
            end
            RTYPE_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            // opcode[0] separates bne (taken on ~zero) from beq (taken on zero)
            BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = {2'b01, opcode_i[1:0]};
                ctrl_o.pc_src    = 2'd1;
                ctrl_o.pc_en     = opcode_i[0] ? ~zero_i : zero_i;
            end
            IMM_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'd2;
                ctrl_o.alu_op    = opcode_i[3:0];
                ctrl_o.ext_zero  = opcode_i[2];
            end
            IMM_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl_o.pc_src = 2'd2;
                ctrl_o.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath control word.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ext_zero,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         PCSrc,
    output logic               pc_en,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e state_q, state_d;
    ctrl_t  ctrl_raw, ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = decode_target(opcode);
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
            RTYPE_EX: state_d = RTYPE_WB;
            RTYPE_WB: state_d = FETCH;
            BRANCH:   state_d = FETCH;
            IMM_EX:   state_d = IMM_WB;
            IMM_WB:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    // Side-effecting strobes are forced low asynchronously while reset is high
    always_comb begin
        ctrl = ctrl_raw;
        if (reset) begin
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.pc_en     = 1'b0;
            ctrl.illegal   = 1'b0;
        end
    end

    assign ALUOp    = ctrl.alu_op;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ext_zero = ctrl.ext_zero;
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign PCSrc    = ctrl.pc_src;
    assign pc_en    = ctrl.pc_en;
    assign illegal  = ctrl.illegal;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through
// its state sequence and compares outputs against hand-derived values.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [3:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ext_zero, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, pc_en, illegal;
    logic [1:0] PCSrc;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ext_zero  (ext_zero),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .PCSrc     (PCSrc),
        .pc_en     (pc_en),
        .illegal   (illegal),
        .state     (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core per-cycle checks: state, write strobes and ALUOp
    task automatic exp_cyc(input string tag, input logic [3:0] st, input logic rw,
                           input logic mw, input logic pe, input logic [3:0] aop);
        check_eq({tag, ".state"},    32'(state),    32'(st));
        check_eq({tag, ".RegWrite"}, 32'(RegWrite), 32'(rw));
        check_eq({tag, ".MemWrite"}, 32'(MemWrite), 32'(mw));
        check_eq({tag, ".pc_en"},    32'(pc_en),    32'(pe));
        check_eq({tag, ".ALUOp"},    32'(ALUOp),    32'(aop));
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // FETCH with mem_ready=1, then DECODE; leaves bench in the first execute state
    task automatic fetch_decode(input string tag, input logic [5:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        exp_cyc({tag, ".F"}, 4'd0, 1'b0, 1'b0, 1'b1, 4'b0010);
        check_eq({tag, ".F.MemRead"}, 32'(MemRead), 32'd1);
        check_eq({tag, ".F.IRWrite"}, 32'(IRWrite), 32'd1);
        check_eq({tag, ".F.ALUSrcB"}, 32'(ALUSrcB), 32'd1);
        tick();
        exp_cyc({tag, ".D"}, 4'd1, 1'b0, 1'b0, 1'b0, 4'b0010);
        check_eq({tag, ".D.ALUSrcB"}, 32'(ALUSrcB), 32'd3);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("rst.state",   32'(state),   32'd0);
        check_eq("rst.MemRead", 32'(MemRead), 32'd0);
        check_eq("rst.IRWrite", 32'(IRWrite), 32'd0);
        check_eq("rst.pc_en",   32'(pc_en),   32'd0);
        #12 reset = 1'b0;

        // FETCH stalls while memory is not ready
        mem_ready = 1'b0;
        #1;
        check_eq("stall.IRWrite", 32'(IRWrite), 32'd0);
        check_eq("stall.pc_en",   32'(pc_en),   32'd0);
        check_eq("stall.MemRead", 32'(MemRead), 32'd1);
        tick();
        check_eq("stall.state", 32'(state), 32'd0);

        // lw
        fetch_decode("lw", 6'b100011);
        exp_cyc("lw.MA", 4'd2, 1'b0, 1'b0, 1'b0, 4'b0010);
        check_eq("lw.MA.ALUSrcA", 32'(ALUSrcA), 32'd1);
        check_eq("lw.MA.ALUSrcB", 32'(ALUSrcB), 32'd2);
        tick();
        exp_cyc("lw.MR", 4'd3, 1'b0, 1'b0, 1'b0, 4'b0010);
        check_eq("lw.MR.IorD",    32'(IorD),    32'd1);
        check_eq("lw.MR.MemRead", 32'(MemRead), 32'd1);
        tick();
        exp_cyc("lw.WB", 4'd4, 1'b1, 1'b0, 1'b0, 4'b0010);
        check_eq("lw.WB.MemtoReg", 32'(MemtoReg), 32'd1);
        check_eq("lw.WB.RegDst",   32'(RegDst),   32'd0);
        tick();

        // sw with three wait cycles
        fetch_decode("sw", 6'b101011);
        exp_cyc("sw.MA", 4'd2, 1'b0, 1'b0, 1'b0, 4'b0010);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_cyc("sw.MW", 4'd5, 1'b0, 1'b1, 1'b0, 4'b0010);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        exp_cyc("sw.MW4", 4'd5, 1'b0, 1'b1, 1'b0, 4'b0010);
        check_eq("sw.MW4.IorD", 32'(IorD), 32'd1);
        tick();
        check_eq("sw.end.state", 32'(state), 32'd0);

        // R-type
        fetch_decode("rt", 6'b000000);
        exp_cyc("rt.EX", 4'd6, 1'b0, 1'b0, 1'b0, 4'b0000);
        check_eq("rt.EX.ALUSrcB", 32'(ALUSrcB), 32'd0);
        tick();
        exp_cyc("rt.WB", 4'd7, 1'b1, 1'b0, 1'b0, 4'b0010);
        check_eq("rt.WB.RegDst", 32'(RegDst), 32'd1);
        tick();

        // beq taken, bne not taken, bne taken
        zero = 1'b1;
        fetch_decode("beq", 6'b000100);
        exp_cyc("beq.BR", 4'd8, 1'b0, 1'b0, 1'b1, 4'b0100);
        check_eq("beq.BR.PCSrc", 32'(PCSrc), 32'd1);
        tick();
        fetch_decode("bne1", 6'b000101);
        exp_cyc("bne1.BR", 4'd8, 1'b0, 1'b0, 1'b0, 4'b0101);
        tick();
        zero = 1'b0;
        fetch_decode("bne0", 6'b000101);
        exp_cyc("bne0.BR", 4'd8, 1'b0, 1'b0, 1'b1, 4'b0101);
        tick();

        // andi / addi
        fetch_decode("andi", 6'b001100);
        exp_cyc("andi.EX", 4'd9, 1'b0, 1'b0, 1'b0, 4'b1100);
        check_eq("andi.EX.ext_zero", 32'(ext_zero), 32'd1);
        check_eq("andi.EX.ALUSrcB",  32'(ALUSrcB),  32'd2);
        tick();
        exp_cyc("andi.WB", 4'd10, 1'b1, 1'b0, 1'b0, 4'b0010);
        check_eq("andi.WB.RegDst", 32'(RegDst), 32'd0);
        tick();
        fetch_decode("addi", 6'b001000);
        exp_cyc("addi.EX", 4'd9, 1'b0, 1'b0, 1'b0, 4'b1000);
        check_eq("addi.EX.ext_zero", 32'(ext_zero), 32'd0);
        tick();
        exp_cyc("addi.WB", 4'd10, 1'b1, 1'b0, 1'b0, 4'b0010);
        tick();

        // jump
        fetch_decode("j", 6'b000010);
        exp_cyc("j.J", 4'd11, 1'b0, 1'b0, 1'b1, 4'b0010);
        check_eq("j.J.PCSrc", 32'(PCSrc), 32'd2);
        tick();

        // illegal opcode: pulse in DECODE, then straight back to FETCH
        opcode    = 6'b111111;
        mem_ready = 1'b1;
        #1;
        check_eq("ill.F.illegal", 32'(illegal), 32'd0);
        tick();
        exp_cyc("ill.D", 4'd1, 1'b0, 1'b0, 1'b0, 4'b0010);
        check_eq("ill.D.illegal", 32'(illegal), 32'd1);
        tick();
        check_eq("ill.next.state",   32'(state),   32'd0);
        check_eq("ill.next.illegal", 32'(illegal), 32'd0);

        // reset in the middle of a stalled store
        fetch_decode("swr", 6'b101011);
        tick();
        mem_ready = 1'b0;
        #1;
        check_eq("swr.MW.MemWrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("swr.rst.MemWrite", 32'(MemWrite), 32'd0);
        check_eq("swr.rst.state",    32'(state),    32'd0);
        check_eq("swr.rst.RegWrite", 32'(RegWrite), 32'd0);
        tick();
        check_eq("swr.rst.hold.MemRead", 32'(MemRead), 32'd0);
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        check_eq("swr.rel.state",   32'(state),   32'd0);
        check_eq("swr.rel.MemRead", 32'(MemRead), 32'd1);
        check_eq("swr.rel.IRWrite", 32'(IRWrite), 32'd1);
        tick();
        check_eq("swr.rel.next", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
